// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and constants for the two-digit BCD seconds stopwatch.
package stopwatch_bcd_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Prescaler width wide enough to hold TICK_DIV-1.
  function automatic int presc_w(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_key.sv
// Push-key conditioning: 2-FF synchroniser, stability counter and a one-cycle
// pulse when the debounced level falls (key pressed).
module key_debounce #(
  parameter int DB_CYC = 240_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= key_n;
      // stage p0 -> p1
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        press <= ~sync_p1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Two-digit BCD seconds stopwatch with debounced start/pause and clear keys,
// driven by a TICK_DIV-cycle prescaler.
module stopwatch_bcd_counter
  import stopwatch_bcd_counter_pkg::*;
#(
  parameter int TICK_DIV = 12_000_000,
  parameter int DB_CYC   = 240_000,
  parameter int WRAP     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start_n,
  input  logic             key_clear_n,
  output logic [BCD_W-1:0] seg_data_1,
  output logic [BCD_W-1:0] seg_data_2,
  output logic             running,
  output logic             wrap_pulse
);

  localparam int PW = presc_w(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          start_press;
  logic          clear_press;
  state_t        state;
  logic [PW-1:0] presc;

  key_debounce #(.DB_CYC(DB_CYC)) u_key_start (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_start_n),
    .press (start_press)
  );

  key_debounce #(.DB_CYC(DB_CYC)) u_key_clear (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_clear_n),
    .press (clear_press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      seg_data_1 <= '0;
      seg_data_2 <= '0;
      running    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      // Clear takes priority over start when both pulse together.
      if (clear_press) begin
        state      <= IDLE;
        presc      <= '0;
        seg_data_1 <= '0;
        seg_data_2 <= '0;
        running    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_press) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (start_press) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
              if (seg_data_2 != BCD_MAX) begin
                seg_data_2 <= seg_data_2 + BCD_W'(1);
              end else if (seg_data_1 != BCD_MAX) begin
                seg_data_2 <= '0;
                seg_data_1 <= seg_data_1 + BCD_W'(1);
              end else if (WRAP != 0) begin
                seg_data_2 <= '0;
                seg_data_1 <= '0;
                wrap_pulse <= 1'b1;
              end else begin
                state   <= DONE;
                running <= 1'b0;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          // Prescaler is left untouched so a resume continues mid-second.
          PAUSE: begin
            if (start_press) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: directed vector table, hand-written corner
// sequences and random key activity checked every cycle against a seconds model.
module tb_stopwatch_bcd_counter;

  localparam int TICK_DIV = 10;
  localparam int DB_CYC   = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ks_n = 1'b1;
  logic       kc_n = 1'b1;
  logic [3:0] d1_tens, d1_ones, d0_tens, d0_ones;
  logic       d1_run, d1_wp, d0_run, d0_wp;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(.TICK_DIV(TICK_DIV), .DB_CYC(DB_CYC), .WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .key_start_n(ks_n), .key_clear_n(kc_n),
    .seg_data_1(d1_tens), .seg_data_2(d1_ones), .running(d1_run), .wrap_pulse(d1_wp)
  );

  stopwatch_bcd_counter #(.TICK_DIV(TICK_DIV), .DB_CYC(DB_CYC), .WRAP(0)) dut_hold (
    .clk(clk), .rst(rst), .key_start_n(ks_n), .key_clear_n(kc_n),
    .seg_data_1(d0_tens), .seg_data_2(d0_ones), .running(d0_run), .wrap_pulse(d0_wp)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: elapsed seconds as an integer, key history as sample queues.
  int m_mode[2];
  int m_sec[2];
  int m_frac[2];
  bit m_wp[2];
  bit kq[2][$];
  bit klvl[2];
  int kcnt[2];
  bit kpend[2];
  bit m_synced;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        kq[k].delete();
        kq[k].push_back(1'b1);
        kq[k].push_back(1'b1);
        klvl[k]  = 1'b1;
        kcnt[k]  = 0;
        kpend[k] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = M_IDLE; m_sec[i] = 0; m_frac[i] = 0; m_wp[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_wp[i] = 1'b0;
        if (kpend[1]) begin
          m_mode[i] = M_IDLE; m_sec[i] = 0; m_frac[i] = 0;
        end else if (m_mode[i] == M_IDLE) begin
          if (kpend[0]) begin m_mode[i] = M_RUN; m_frac[i] = 0; end
        end else if (m_mode[i] == M_PAUSE) begin
          if (kpend[0]) m_mode[i] = M_RUN;
        end else if (m_mode[i] == M_RUN) begin
          if (kpend[0]) m_mode[i] = M_PAUSE;
          else if (m_frac[i] == TICK_DIV - 1) begin
            m_frac[i] = 0;
            if (m_sec[i] < 99) m_sec[i]++;
            else if (i == 1) begin m_sec[i] = 0; m_wp[i] = 1'b1; end
            else m_mode[i] = M_DONE;
          end else m_frac[i]++;
        end
      end
      for (int k = 0; k < 2; k++) begin
        m_synced = kq[k].pop_front();
        kq[k].push_back(k == 0 ? ks_n : kc_n);
        kpend[k] = 1'b0;
        if (m_synced != klvl[k]) begin
          kcnt[k]++;
          if (kcnt[k] == DB_CYC) begin
            klvl[k] = m_synced; kcnt[k] = 0; kpend[k] = !m_synced;
          end
        end else kcnt[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_wrap_tens", d1_tens, m_sec[1] / 10);
      check("m_wrap_ones", d1_ones, m_sec[1] % 10);
      check("m_wrap_run",  d1_run,  m_mode[1] == M_RUN);
      check("m_wrap_wp",   d1_wp,   m_wp[1]);
      check("m_hold_tens", d0_tens, m_sec[0] / 10);
      check("m_hold_ones", d0_ones, m_sec[0] % 10);
      check("m_hold_run",  d0_run,  m_mode[0] == M_RUN);
      check("m_hold_wp",   d0_wp,   m_wp[0]);
    end
  end

  typedef struct {
    logic start_n;
    logic clear_n;
    int   cycles;
    int   tens;
    int   ones;
    logic run;
  } vec_t;

  vec_t tbl[4];
  int   wp_cycles;
  bit   seen;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 50,  0, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 20,  0, 1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 937, 9, 5, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 40,  9, 9, 1'b1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tens", d1_tens, 0);
    check("rst_ones", d1_ones, 0);
    check("rst_run",  d1_run,  0);
    check("rst_wp",   d1_wp,   0);
    rst = 1'b0;
    chk_en = 1'b1;

    for (int v = 0; v < 4; v++) begin
      ks_n = tbl[v].start_n;
      kc_n = tbl[v].clear_n;
      repeat (tbl[v].cycles) @(negedge clk);
      check($sformatf("vec%0d_tens", v), d1_tens, tbl[v].tens);
      check($sformatf("vec%0d_ones", v), d1_ones, tbl[v].ones);
      check($sformatf("vec%0d_run", v),  d1_run,  tbl[v].run);
    end

    // Rollover: one-cycle wrap pulse on the wrapping copy, hold at 99 on the other.
    wp_cycles = 0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d1_wp) begin
        wp_cycles++;
        if (!seen) begin
          seen = 1'b1;
          check("wrap_tens", d1_tens, 0);
          check("wrap_ones", d1_ones, 0);
          check("wrap_run",  d1_run,  1);
        end
      end
    end
    check("wrap_seen",  seen, 1);
    check("wrap_width", wp_cycles, 1);
    check("done_run",  d0_run,  0);
    check("done_tens", d0_tens, 9);
    check("done_ones", d0_ones, 9);

    // Bounce shorter than the debounce window.
    ks_n = 1'b0; repeat (2) @(negedge clk);
    ks_n = 1'b1; repeat (2) @(negedge clk);
    ks_n = 1'b0; repeat (2) @(negedge clk);
    ks_n = 1'b1; repeat (12) @(negedge clk);
    check("bounce_run", d1_run, 1);

    // Start in DONE is ignored.
    ks_n = 1'b0; repeat (10) @(negedge clk);
    ks_n = 1'b1; repeat (5) @(negedge clk);
    check("done_start_run",  d0_run,  0);
    check("done_start_tens", d0_tens, 9);
    check("done_start_ones", d0_ones, 9);

    kc_n = 1'b0; repeat (10) @(negedge clk);
    kc_n = 1'b1; repeat (5) @(negedge clk);
    check("clr_tens", d0_tens, 0);
    check("clr_ones", d0_ones, 0);
    check("clr_run",  d0_run,  0);
    check("clr_wrap_ones", d1_ones, 0);

    // Pause at count 12 with prescaler 3, then resume mid-second.
    ks_n = 1'b0; repeat (10) @(negedge clk);
    ks_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (m_mode[1] == M_RUN && m_sec[1] == 11 && m_frac[1] == 7) seen = 1'b1;
    end
    check("pause_sync_found", seen, 1);
    ks_n = 1'b0;
    repeat (6) @(negedge clk);
    check("pause_pre_run", d1_run, 1);
    @(negedge clk);
    check("pause_run",  d1_run,  0);
    check("pause_tens", d1_tens, 1);
    check("pause_ones", d1_ones, 2);
    ks_n = 1'b1;
    repeat (50) @(negedge clk);
    check("hold_tens", d1_tens, 1);
    check("hold_ones", d1_ones, 2);
    ks_n = 1'b0;
    repeat (7) @(negedge clk);
    check("resume_run", d1_run, 1);
    repeat (6) @(negedge clk);
    check("resume_ones_pre", d1_ones, 2);
    @(negedge clk);
    check("resume_ones", d1_ones, 3);
    ks_n = 1'b1;
    repeat (20) @(negedge clk);

    // Start and clear pulses on the same cycle while running.
    check("both_pre_run", d1_run, 1);
    ks_n = 1'b0; kc_n = 1'b0;
    repeat (8) @(negedge clk);
    check("both_run",  d1_run,  0);
    check("both_tens", d1_tens, 0);
    check("both_ones", d1_ones, 0);
    check("both_hold_run", d0_run, 0);
    ks_n = 1'b1; kc_n = 1'b1;
    repeat (20) @(negedge clk);

    // Random key activity, bounces and occasional resets.
    for (int it = 0; it < 200; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act <= 5) begin
        repeat ($urandom_range(5, 40)) @(negedge clk);
      end else if (act <= 7) begin
        ks_n = 1'b0; repeat ($urandom_range(1, 8)) @(negedge clk);
        ks_n = 1'b1; repeat ($urandom_range(1, 30)) @(negedge clk);
      end else if (act == 8) begin
        kc_n = 1'b0; repeat ($urandom_range(1, 8)) @(negedge clk);
        kc_n = 1'b1; repeat ($urandom_range(1, 30)) @(negedge clk);
      end else begin
        rst = 1'b1; repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0; @(negedge clk);
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Two-digit BCD seconds stopwatch (00–99) driving the dual 7-segment decoder directly.
- Outputs seg_data_1 (tens, left digit) and seg_data_2 (ones, right digit) as 4-bit BCD, always 0–9.
- Start/pause and clear come from on-board push keys (active-low, bouncy), which are synchronised and debounced inside the block.
- Count advances on a 1 Hz tick derived from the 12 MHz board clock.

Parameters:
- TICK_DIV, 12_000_000: clk cycles per count tick (1 s at 12 MHz); must be ≥2.
- DB_CYC, 240_000: cycles a synchronised key level must be stable before it is accepted (20 ms).
- WRAP, 1: 1 = 99 rolls to 00 and keeps running; 0 = stop and hold at 99.

Ports:
- clk  input  1  board clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_start_n  input  1  start/pause key, active-low, asynchronous, bouncy.
- key_clear_n  input  1  clear key, active-low, asynchronous, bouncy.
- seg_data_1  output  4  tens digit, BCD 0–9.
- seg_data_2  output  4  ones digit, BCD 0–9.
- running  output  1  high while in RUN.
- wrap_pulse  output  1  one-cycle pulse on the 99→00 rollover (WRAP=1 only).

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - seg_data_1 = 0, seg_data_2 = 0, running = 0, wrap_pulse = 0.
  - State IDLE, prescaler = 0.
  - Debounced key levels = 1 (released); debounce counters = 0.
  - rst asserted mid-count or mid-debounce overrides everything on that edge.
- Key path, per key:
  - 2-FF synchroniser.
  - Debounce counter reloads to 0 whenever the synchronised level equals the current debounced level. Otherwise it increments; when it reaches DB_CYC-1 the debounced level flips.
  - A 1→0 flip of the debounced level produces a one-cycle press pulse. Release produces nothing.
  - Latency from a clean key edge to the press pulse: 2 + DB_CYC cycles.
- FSM states and transitions (press pulses are evaluated on the cycle they are high):
  - IDLE: start → RUN, prescaler cleared to 0.
  - RUN: start → PAUSE.
  - PAUSE: start → RUN, prescaler retained so resume continues mid-second.
  - DONE: start is ignored.
  - Clear, in any state → IDLE, digits 00, prescaler 0, wrap_pulse 0. Clear wins over start on the same cycle.
- Prescaler and count:
  - Prescaler counts only in RUN and holds in every other state.
  - When prescaler == TICK_DIV-1: next cycle prescaler = 0 and the BCD count increments.
  - Ones 9 → 0 carries into tens.
  - Count 99 with WRAP=1: becomes 00, wrap_pulse = 1 for exactly that one cycle, state stays RUN.
  - Count 99 with WRAP=0: digits stay 99, state → DONE, running = 0.
- Timing: digits update on the clock edge after the terminal prescaler count. running is registered and reflects the current state.
- Invariant: no digit ever takes a value of 10–15.

Decomposition:
- Shared package:
  - State enum {IDLE, RUN, PAUSE, DONE}.
  - BCD digit width constant (4) and BCD_MAX = 9.
  - Prescaler width derived from $clog2(TICK_DIV).
- One sub-module: key_debounce (synchroniser + stability counter + press pulse, parameter DB_CYC). Instantiated twice.

Test Plan (TICK_DIV=10, DB_CYC=4 unless stated):
1. Assert rst 3 cycles with keys high → all outputs 0, running=0. Hold 50 cycles → digits stay 00.
2. Drive key_start_n low 20 cycles → press pulse 6 cycles after the edge, running=1. After 950 further cycles → seg_data_1=9, seg_data_2=5.
3. Continue from 99 → on the tick the digits become 00, wrap_pulse high for exactly 1 cycle, running stays 1.
4. Bounce: key_start_n low 2 cycles, high 2, low 2, then high → no press pulse, state unchanged.
5. Pause/resume:
   - Press start while count = 12 with prescaler = 3 → PAUSE; digits hold 12 for 50 cycles.
   - Press start again → RUN; count reaches 13 exactly 7 cycles after RUN is re-entered.
6. WRAP=0 and clear priority:
   - Run to 99 → DONE, running=0, digits 99; a start press is ignored.
   - Clear press → IDLE, digits 00.
   - Start and clear press pulses on the same cycle in RUN → IDLE, digits 00.
